// File: rtl/uart_alu_interface_if.sv
// ---------------------------------------------------------------------------
// uart_alu_interface_if
//   Bundles the byte stream, ALU and transmitter signals of the UART/ALU
//   protocol engine.
//   slave  : the protocol engine (consumes rx bytes and ALU result, drives
//            operands, opcode, tx byte/start, busy and drop).
//   master : the surrounding environment (UART rx/tx pair and ALU).
//   Signals:
//     i_tick          16x baud tick pulse
//     i_rx_data_valid received byte strobe
//     i_rx_data       received byte
//     i_alu_result    combinational ALU output
//     o_alu_data_a/b  registered operands
//     o_alu_op        registered opcode
//     o_tx_data       registered transmit byte
//     o_tx_start      one-cycle transmit start
//     o_busy          command in flight (SEND / WAIT_TX)
//     o_drop          one-cycle pulse, a received byte was discarded
// ---------------------------------------------------------------------------
interface uart_alu_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_tick;
  logic               i_rx_data_valid;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_data_a;
  logic [NB_DATA-1:0] o_alu_data_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_drop;

  modport slave (
    input  i_tick, i_rx_data_valid, i_rx_data, i_alu_result,
    output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
           o_tx_start, o_busy, o_drop
  );

  modport master (
    output i_tick, i_rx_data_valid, i_rx_data, i_alu_result,
    input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
           o_tx_start, o_busy, o_drop
  );
endinterface

// File: rtl/uart_alu_interface.sv
// ---------------------------------------------------------------------------
// uart_alu_interface
//   Collects operand A, operand B and opcode bytes from the UART receiver,
//   presents them to a combinational ALU, captures the result and launches
//   it on the UART transmitter, then refuses new bytes until the frame plus
//   a guard interval has elapsed (counted in 16x baud ticks).
//   Ports:
//     i_clock  system clock, rising edge
//     i_reset  synchronous active-high reset
//     bus      uart_alu_interface_if.slave (rx stream, ALU, tx, status)
// ---------------------------------------------------------------------------
module uart_alu_interface #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int NB_STOP     = 1,
  parameter int GUARD_TICKS = 16,
  parameter int FRAME_TICKS = 16*(1+NB_DATA+NB_STOP)+GUARD_TICKS,
  parameter int NB_TICK_CNT = $clog2(FRAME_TICKS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_interface_if.slave   bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [NB_TICK_CNT-1:0] LAST_TICK = NB_TICK_CNT'(FRAME_TICKS-1);

  state_t                 state_q;
  logic [NB_TICK_CNT-1:0] cnt_q;
  logic [NB_DATA-1:0]     a_q;
  logic [NB_DATA-1:0]     b_q;
  logic [NB_OP-1:0]       op_q;
  logic [NB_DATA-1:0]     tx_data_q;
  logic                   tx_start_q;
  logic                   drop_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (bus.i_rx_data_valid) begin
            a_q     <= bus.i_rx_data;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.i_rx_data_valid) begin
            b_q     <= bus.i_rx_data;
            state_q <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (bus.i_rx_data_valid) begin
            op_q    <= bus.i_rx_data[NB_OP-1:0];
            state_q <= SEND;
          end
        end
        SEND: begin
          // The ALU has had the whole SEND cycle to settle on the new opcode.
          tx_data_q  <= bus.i_alu_result;
          tx_start_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= WAIT_TX;
          if (bus.i_rx_data_valid) drop_q <= 1'b1;
        end
        WAIT_TX: begin
          if (bus.i_tick) begin
            if (cnt_q == LAST_TICK) begin
              cnt_q   <= '0;
              state_q <= WAIT_A;
            end else begin
              cnt_q <= cnt_q + NB_TICK_CNT'(1);
            end
          end
          // A byte arriving on the exit cycle is still discarded.
          if (bus.i_rx_data_valid) drop_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT_A;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.o_alu_data_a = a_q;
  assign bus.o_alu_data_b = b_q;
  assign bus.o_alu_op     = op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_drop       = drop_q;
  assign bus.o_busy       = (state_q == SEND) || (state_q == WAIT_TX);

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Byte-level protocol engine that sits between the UART receive/transmit pair and a combinational ALU. It collects three consecutive received bytes (operand A, operand B, opcode) from the UART receiver and holds them as ALU inputs. It then captures the ALU result, launches it on the UART transmitter, and blocks new commands until that frame has left the line. It is the consumer of the UART byte stream and the producer of the byte the transmitter sends back.

## Interface
- NB_DATA, 8, data/operand/result width in bits (= UART frame data bits)
- NB_OP, 6, opcode width; low NB_OP bits of the third byte
- NB_STOP, 1, stop bits per UART frame
- GUARD_TICKS, 16, extra baud ticks waited after a frame before accepting a new command
- FRAME_TICKS, 16*(1+NB_DATA+NB_STOP)+GUARD_TICKS, total ticks spent in WAIT_TX
- NB_TICK_CNT, $clog2(FRAME_TICKS), tick counter width
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_tick  in  1  16x baud-rate tick pulse, one cycle wide
- i_rx_data_valid  in  1  one-cycle pulse, received byte available
- i_rx_data  in  NB_DATA  received byte, valid with i_rx_data_valid
- i_alu_result  in  NB_DATA  combinational ALU output
- o_alu_data_a  out  NB_DATA  registered operand A
- o_alu_data_b  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- o_tx_data  out  NB_DATA  registered byte for the transmitter
- o_tx_start  out  1  one-cycle transmit start pulse
- o_busy  out  1  high in SEND and WAIT_TX
- o_drop  out  1  one-cycle pulse when a received byte is discarded

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX. Reset state is WAIT_A.
- WAIT_A: on i_rx_data_valid, o_alu_data_a <= i_rx_data, then go to WAIT_B.
- WAIT_B: on i_rx_data_valid, o_alu_data_b <= i_rx_data, then go to WAIT_OP.
- WAIT_OP: on i_rx_data_valid, o_alu_op <= i_rx_data[NB_OP-1:0], then go to SEND. Upper byte bits are ignored.
- SEND takes exactly one cycle: o_tx_data <= i_alu_result, o_tx_start <= 1, tick counter <= 0, then go to WAIT_TX.
- WAIT_TX: the counter increments on each i_tick. When i_tick arrives with counter == FRAME_TICKS-1, go to WAIT_A and clear the counter.
- i_rx_data_valid while in SEND or WAIT_TX: the byte is discarded, o_drop pulses in the next cycle, and no register or state changes.
- The operand and opcode registers hold their values until overwritten by the next command. They are not cleared on return to WAIT_A.
- o_busy is decoded combinationally from the state.
- Reset (i_reset high at a clock edge) applies from any state, including mid-command or mid-WAIT_TX:
  - state returns to WAIT_A and the counter goes to 0;
  - o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data = 0;
  - o_tx_start, o_drop, o_busy = 0;
  - a partially collected command is lost.
- Reset has priority over i_rx_data_valid and i_tick in the same cycle.

## Timing
- Opcode byte valid in cycle N:
  - o_alu_op updates and state = SEND from cycle N+1.
  - i_alu_result is sampled at the end of cycle N+1.
  - o_tx_data is valid and o_tx_start is high in cycle N+2 only.
  - State is WAIT_TX from cycle N+2.
- The ALU is purely combinational. One full cycle of settling between opcode capture and result sampling is guaranteed.
- Counter behaviour in WAIT_TX:
  - i_tick in the same cycle as the SEND→WAIT_TX transition is not counted.
  - The counter wraps to 0 only on exit, never past FRAME_TICKS-1.
- Return to WAIT_A occurs on the edge after the FRAME_TICKS-th tick. A byte valid in that same cycle is dropped; the first acceptable byte is valid in the following cycle.
- Back-to-back rx bytes in consecutive cycles are each accepted in the WAIT_A/B/OP states. There is no minimum spacing.

## Test plan
- Bench ALU model is result = a + b.
- **Basic command:** rx bytes 0x05, 0x03, 0x20 →
  - o_alu_data_a = 0x05, o_alu_data_b = 0x03, o_alu_op = 0x20;
  - o_tx_data = 0x08;
  - exactly one o_tx_start pulse, 2 cycles after the opcode valid.
- **Busy and return timing:** after the basic command, apply exactly FRAME_TICKS = 176 ticks →
  - o_busy stays high through tick 175;
  - o_busy goes low 1 cycle after tick 176;
  - a new command 0x10, 0x01, 0x00 then yields o_tx_data = 0x11.
- **Drop during busy:** rx byte 0xAA 10 ticks into WAIT_TX →
  - o_drop pulses once;
  - o_alu_data_a remains 0x05;
  - no extra o_tx_start.
- **Opcode truncation:** third byte 0xFF → o_alu_op = 0x3F.
- **Reset mid-command:** bytes 0x07, 0x09, then i_reset for 1 cycle, then bytes 0x01, 0x02, 0x00 →
  - all outputs are 0 after reset;
  - o_tx_data = 0x03;
  - one o_tx_start total.
- **Reset during WAIT_TX:** reset 50 ticks in →
  - o_busy = 0 next cycle;
  - an immediate new command is accepted and transmitted.
